// File: rtl/mips_alu_if.sv
// Shared ALU control encoding and the three port bundles used by mips_alu.
//
// mips_alu_pkg::alu_ctl_t : decoded operation select.
// alu_input_ifc  : valid, alu_ctl, op1, op2   (D2E register -> ALU)
// alu_output_ifc : valid, result, branch_outcome (ALU -> EX glue)
// pass_done_ifc  : done, result               (simulation test-control flag)
// Each interface has a master modport (the driver) and a slave modport
// (the receiver).

package mips_alu_pkg;

  typedef enum logic [4:0] {
    ALU_NOP       = 5'd0,
    ALU_ADD       = 5'd1,
    ALU_ADDU      = 5'd2,
    ALU_SUB       = 5'd3,
    ALU_SUBU      = 5'd4,
    ALU_AND       = 5'd5,
    ALU_OR        = 5'd6,
    ALU_XOR       = 5'd7,
    ALU_NOR       = 5'd8,
    ALU_SLT       = 5'd9,
    ALU_SLTU      = 5'd10,
    ALU_SLL       = 5'd11,
    ALU_SRL       = 5'd12,
    ALU_SRA       = 5'd13,
    ALU_SLLV      = 5'd14,
    ALU_SRLV      = 5'd15,
    ALU_SRAV      = 5'd16,
    ALU_BA        = 5'd17,
    ALU_BEQ       = 5'd18,
    ALU_BNE       = 5'd19,
    ALU_BLEZ      = 5'd20,
    ALU_BGTZ      = 5'd21,
    ALU_BGEZ      = 5'd22,
    ALU_BLTZ      = 5'd23,
    ALU_MTC0_PASS = 5'd24,
    ALU_MTC0_FAIL = 5'd25,
    ALU_MTC0_DONE = 5'd26
  } alu_ctl_t;

  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

endpackage

interface alu_input_ifc #(
  parameter int DATA_WIDTH = 32
);
  import mips_alu_pkg::*;

  logic                  valid;
  alu_ctl_t              alu_ctl;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;

  modport master (output valid, alu_ctl, op1, op2);
  modport slave  (input  valid, alu_ctl, op1, op2);
endinterface

interface alu_output_ifc #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] result;
  logic                  branch_outcome;

  modport master (output valid, result, branch_outcome);
  modport slave  (input  valid, result, branch_outcome);
endinterface

interface pass_done_ifc;
  logic done;
  logic result;

  modport master (output done, result);
  modport slave  (input  done, result);
endinterface

// File: rtl/mips_alu.sv
// Execute-stage ALU of the 5-stage MIPS32 core.
//
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset (clears the pass/done flag only)
//   in         : alu_input_ifc.slave  - valid, alu_ctl, op1, op2
//   out        : alu_output_ifc.master - valid, result, branch_outcome
//                (purely combinational from in.*)
//   pass_done  : pass_done_ifc.master - sticky test-program done/pass flag,
//                loaded by the first valid MTC0 test-control op.

module mips_alu
  import mips_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_input_ifc.slave          in,
  alu_output_ifc.master        out,
  pass_done_ifc.master         pass_done
);

  logic [DATA_WIDTH-1:0] result;
  logic                  branch_outcome;
  logic [4:0]            shamt;

  logic done_q, done_d;
  logic pass_q, pass_d;

  // Shift amount comes only from the low five bits of op2.
  assign shamt = in.op2[4:0];

  always_comb begin
    result         = '0;
    branch_outcome = NOT_TAKEN;
    done_d         = done_q;
    pass_d         = pass_q;

    if (in.valid) begin
      case (in.alu_ctl)
        ALU_ADD, ALU_ADDU: result = in.op1 + in.op2;
        ALU_SUB, ALU_SUBU: result = in.op1 - in.op2;
        ALU_AND:           result = in.op1 & in.op2;
        ALU_OR:            result = in.op1 | in.op2;
        ALU_XOR:           result = in.op1 ^ in.op2;
        ALU_NOR:           result = ~(in.op1 | in.op2);
        ALU_SLT:           result = {{(DATA_WIDTH-1){1'b0}},
                                     ($signed(in.op1) < $signed(in.op2))};
        ALU_SLTU:          result = {{(DATA_WIDTH-1){1'b0}}, (in.op1 < in.op2)};
        ALU_SLL, ALU_SLLV: result = in.op1 << shamt;
        ALU_SRL, ALU_SRLV: result = in.op1 >> shamt;
        ALU_SRA, ALU_SRAV: result = $unsigned($signed(in.op1) >>> shamt);
        ALU_BA:            branch_outcome = TAKEN;
        ALU_BEQ:           branch_outcome = (in.op1 == in.op2);
        ALU_BNE:           branch_outcome = (in.op1 != in.op2);
        // Sign-based branches only look at op1; zero test covers the "or equal".
        ALU_BLEZ:          branch_outcome = in.op1[DATA_WIDTH-1] | (in.op1 == '0);
        ALU_BGTZ:          branch_outcome = ~in.op1[DATA_WIDTH-1] & (in.op1 != '0);
        ALU_BGEZ:          branch_outcome = ~in.op1[DATA_WIDTH-1];
        ALU_BLTZ:          branch_outcome = in.op1[DATA_WIDTH-1];
        // The first test-control op after reset wins; later ones are ignored.
        ALU_MTC0_PASS: begin
          if (!done_q) begin
            done_d = 1'b1;
            pass_d = 1'b1;
          end
        end
        ALU_MTC0_FAIL: begin
          if (!done_q) begin
            done_d = 1'b1;
            pass_d = 1'b0;
          end
        end
        ALU_MTC0_DONE: begin
          if (!done_q) begin
            done_d = 1'b1;
            pass_d = 1'b1;
          end
        end
        default: begin
          result         = '0;
          branch_outcome = NOT_TAKEN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  assign out.valid          = in.valid;
  assign out.result         = result;
  assign out.branch_outcome = branch_outcome;

  assign pass_done.done   = done_q;
  assign pass_done.result = pass_q;

endmodule

// File: tb/tb_mips_alu.sv
// Directed testbench for mips_alu: hand-computed vectors for arithmetic,
// logic, shifts, branches, valid gating and the sticky pass/done flag.

module tb_mips_alu;
  import mips_alu_pkg::*;

  logic clk;
  logic rst_n;

  int vectors     = 0;
  int miscompares = 0;

  alu_input_ifc  #(.DATA_WIDTH(32)) in_if ();
  alu_output_ifc #(.DATA_WIDTH(32)) out_if ();
  pass_done_ifc                     pd_if ();

  mips_alu #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_if),
    .out       (out_if),
    .pass_done (pd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
    $display("vec %0d %s: observed 0x%08h expected 0x%08h", vectors, tag, obs, exp);
  endtask

  task automatic drive(input alu_ctl_t ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic v);
    in_if.valid   = v;
    in_if.alu_ctl = ctl;
    in_if.op1     = a;
    in_if.op2     = b;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_if.valid = 1'b0;
    in_if.alu_ctl = ALU_NOP;
    in_if.op1 = '0;
    in_if.op2 = '0;
    #1;
    chk("reset_done", {31'b0, pd_if.done}, 32'd0);
    chk("reset_result", {31'b0, pd_if.result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic and logic
    drive(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
    chk("add_wrap", out_if.result, 32'h0000_0000);
    chk("add_valid", {31'b0, out_if.valid}, 32'd1);
    chk("add_br", {31'b0, out_if.branch_outcome}, 32'd0);
    drive(ALU_SUB, 32'd5, 32'd7, 1'b1);
    chk("sub", out_if.result, 32'hFFFF_FFFE);
    drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1);
    chk("slt", out_if.result, 32'd1);
    drive(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b1);
    chk("sltu", out_if.result, 32'd0);
    drive(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    chk("and", out_if.result, 32'hF000_F000);
    drive(ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F, 1'b1);
    chk("or", out_if.result, 32'hF0F0_0F0F);
    drive(ALU_XOR, 32'hFFFF_0000, 32'hF0F0_F0F0, 1'b1);
    chk("xor", out_if.result, 32'h0F0F_F0F0);
    drive(ALU_NOR, 32'hF0F0_F0F0, 32'h0F0F_0000, 1'b1);
    chk("nor", out_if.result, 32'h0000_0F0F);

    // Shifts
    drive(ALU_SRA, 32'h8000_0000, 32'd4, 1'b1);
    chk("sra", out_if.result, 32'hF800_0000);
    drive(ALU_SRL, 32'h8000_0000, 32'd4, 1'b1);
    chk("srl", out_if.result, 32'h0800_0000);
    drive(ALU_SLL, 32'h8000_0000, 32'h24, 1'b1);
    chk("sll_amt_mask", out_if.result, 32'h0000_0000);
    drive(ALU_SLLV, 32'd1, 32'h21, 1'b1);
    chk("sllv_amt_mask", out_if.result, 32'd2);
    drive(ALU_SRAV, 32'h7000_0000, 32'd4, 1'b1);
    chk("srav_pos", out_if.result, 32'h0700_0000);

    // Branches
    drive(ALU_BEQ, 32'd3, 32'd3, 1'b1);
    chk("beq_taken", {31'b0, out_if.branch_outcome}, 32'd1);
    chk("beq_result", out_if.result, 32'd0);
    drive(ALU_BNE, 32'd3, 32'd3, 1'b1);
    chk("bne_not", {31'b0, out_if.branch_outcome}, 32'd0);
    drive(ALU_BLEZ, 32'd0, 32'd0, 1'b1);
    chk("blez_zero", {31'b0, out_if.branch_outcome}, 32'd1);
    drive(ALU_BGTZ, 32'h8000_0000, 32'd0, 1'b1);
    chk("bgtz_neg", {31'b0, out_if.branch_outcome}, 32'd0);
    drive(ALU_BGTZ, 32'd1, 32'd0, 1'b1);
    chk("bgtz_pos", {31'b0, out_if.branch_outcome}, 32'd1);
    drive(ALU_BGEZ, 32'd0, 32'd0, 1'b1);
    chk("bgez_zero", {31'b0, out_if.branch_outcome}, 32'd1);
    drive(ALU_BLTZ, 32'h8000_0000, 32'd0, 1'b1);
    chk("bltz_neg", {31'b0, out_if.branch_outcome}, 32'd1);
    drive(ALU_BA, 32'd0, 32'd0, 1'b1);
    chk("ba", {31'b0, out_if.branch_outcome}, 32'd1);

    // Valid gating
    drive(ALU_ADD, 32'd1, 32'd2, 1'b0);
    chk("inv_valid", {31'b0, out_if.valid}, 32'd0);
    chk("inv_result", out_if.result, 32'd0);
    chk("inv_br", {31'b0, out_if.branch_outcome}, 32'd0);
    drive(ALU_BA, 32'd0, 32'd0, 1'b0);
    chk("inv_ba", {31'b0, out_if.branch_outcome}, 32'd0);
    drive(ALU_MTC0_PASS, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    chk("inv_mtc0_done", {31'b0, pd_if.done}, 32'd0);

    // Sticky flag: FAIL first
    @(negedge clk);
    drive(ALU_MTC0_FAIL, 32'd0, 32'd0, 1'b1);
    chk("fail_pre_edge_done", {31'b0, pd_if.done}, 32'd0);
    chk("fail_comb_result", out_if.result, 32'd0);
    @(posedge clk); #1;
    chk("fail_done", {31'b0, pd_if.done}, 32'd1);
    chk("fail_result", {31'b0, pd_if.result}, 32'd0);
    @(negedge clk);
    drive(ALU_MTC0_PASS, 32'd0, 32'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("sticky_done", {31'b0, pd_if.done}, 32'd1);
    chk("sticky_result", {31'b0, pd_if.result}, 32'd0);

    // Asynchronous reset mid-cycle; comb path keeps working
    #2;
    rst_n = 1'b0;
    drive(ALU_ADD, 32'd2, 32'd3, 1'b1);
    chk("rst_done", {31'b0, pd_if.done}, 32'd0);
    chk("rst_result", {31'b0, pd_if.result}, 32'd0);
    chk("rst_add", out_if.result, 32'd5);
    drive(ALU_NOP, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(ALU_MTC0_PASS, 32'd0, 32'd0, 1'b1);
    @(posedge clk); #1;
    chk("pass_done", {31'b0, pd_if.done}, 32'd1);
    chk("pass_result", {31'b0, pd_if.result}, 32'd1);

    // Simultaneity with MTC0_DONE
    @(negedge clk);
    rst_n = 1'b0;
    drive(ALU_NOP, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(ALU_MTC0_DONE, 32'h1234_5678, 32'h1, 1'b1);
    chk("mdone_comb_result", out_if.result, 32'd0);
    chk("mdone_comb_valid", {31'b0, out_if.valid}, 32'd1);
    chk("mdone_pre_edge", {31'b0, pd_if.done}, 32'd0);
    @(posedge clk); #1;
    chk("mdone_done", {31'b0, pd_if.done}, 32'd1);
    chk("mdone_result", {31'b0, pd_if.result}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
